serial_to_parallel: RTL and testbench

Deserializer that sits directly downstream of the parallel_to_serial stage and consumes its serial_out stream, one bit per clk.
- Detects a start bit and shifts in WIDTH data bits.
- Optionally checks an even-parity bit, then checks the stop bit.
- Presents each good word on a held output with a valid/ack handshake toward the consumer.
- Flags framing, parity and overrun errors.

---
 rtl/serial_to_parallel.sv | 159 +++++++++++++++
 tb/tb_serial_to_parallel.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// Serial deserializer: start bit, WIDTH data bits, optional even parity, stop bit.
// Good words are held on data_out behind a valid/ack handshake; errors pulse for one cycle.
module serial_to_parallel #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_in;
  logic             par_bit_q, par_bit_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             parity_ok;

  // Shift direction: MSB-first enters at bit 0 and moves up, LSB-first enters at the top.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_entry
          assign shift_in[gi] = serial_in;
        end else begin : g_move
          assign shift_in[gi] = shift_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_entry
          assign shift_in[gi] = serial_in;
        end else begin : g_move
          assign shift_in[gi] = shift_q[gi+1];
        end
      end
    end
  endgenerate

  assign parity_ok = ~((^shift_q) ^ par_bit_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    data_d       = data_q;
    valid_d      = valid_q & ~data_ack;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!serial_in) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        shift_d = shift_in;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        par_bit_d = serial_in;
        state_d   = S_STOP;
      end
      S_STOP: begin
        if (!serial_in) begin
          // A bad stop bit hides any parity result for the same frame.
          frame_err_d = 1'b1;
          state_d     = S_WAIT_IDLE;
        end else begin
          state_d = S_IDLE;
          if (PARITY_EN && !parity_ok) begin
            parity_err_d = 1'b1;
          end else if (!valid_q || data_ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (serial_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: a 4-bit MSB-first instance and an
// 8-bit LSB-first instance with parity, expected words tracked in scoreboards.
module tb_serial_to_parallel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_serial = 1'b1, a_ack = 1'b0;
  logic [3:0] a_data;
  logic       a_valid, a_fe, a_pe, a_ov, a_busy;

  logic       b_rst = 1'b1, b_serial = 1'b1, b_ack = 1'b0;
  logic [7:0] b_data;
  logic       b_valid, b_fe, b_pe, b_ov, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sb_a[$];
  logic [7:0] sb_b[$];

  serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .rst(a_rst), .serial_in(a_serial), .data_ack(a_ack),
    .data_out(a_data), .data_valid(a_valid), .frame_err(a_fe),
    .parity_err(a_pe), .overrun(a_ov), .busy(a_busy)
  );

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .serial_in(b_serial), .data_ack(b_ack),
    .data_out(b_data), .data_valid(b_valid), .frame_err(b_fe),
    .parity_err(b_pe), .overrun(b_ov), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_bit(input logic b);
    a_serial = b;
    step();
  endtask

  task automatic b_bit(input logic b);
    b_serial = b;
    step();
  endtask

  task automatic a_frame(input logic [3:0] w, input logic stop, input logic ack_start,
                         input logic exp_del, input logic exp_ovr);
    logic [3:0] exp_w;
    if (exp_del) sb_a.push_back(w);
    a_ack = ack_start;
    a_bit(1'b0);
    a_ack = 1'b0;
    chk("a_busy_start", a_busy, 1);
    if (ack_start) chk("a_ack_clear", a_valid, 0);
    for (int i = 3; i >= 0; i--) a_bit(w[i]);
    chk("a_busy_data", a_busy, 1);
    a_bit(stop);
    chk("a_busy_stop", a_busy, !stop);
    chk("a_frame_err", a_fe, !stop);
    chk("a_parity_err", a_pe, 0);
    chk("a_overrun", a_ov, exp_ovr);
    if (exp_del) begin
      exp_w = sb_a.pop_front();
      chk("a_word", a_data, exp_w);
      chk("a_valid", a_valid, 1);
    end
    $display("A frame %h stop=%0b -> data_out=%h valid=%0b fe=%0b ov=%0b",
             w, stop, a_data, a_valid, a_fe, a_ov);
  endtask

  task automatic b_frame(input logic [7:0] w, input logic par, input logic stop,
                         input logic ack_stop, input logic exp_del, input logic exp_pe);
    logic [7:0] exp_w;
    if (exp_del) sb_b.push_back(w);
    b_bit(1'b0);
    chk("b_busy_start", b_busy, 1);
    for (int i = 0; i < 8; i++) b_bit(w[i]);
    b_bit(par);
    b_ack = ack_stop;
    b_bit(stop);
    b_ack = 1'b0;
    chk("b_frame_err", b_fe, !stop);
    chk("b_parity_err", b_pe, exp_pe);
    chk("b_overrun", b_ov, 0);
    if (exp_del) begin
      exp_w = sb_b.pop_front();
      chk("b_word", b_data, exp_w);
      chk("b_valid", b_valid, 1);
    end
    $display("B frame %h par=%0b stop=%0b -> data_out=%h valid=%0b fe=%0b pe=%0b",
             w, par, stop, b_data, b_valid, b_fe, b_pe);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rw;

    // Reset both instances
    step();
    step();
    chk("a_reset", {a_busy, a_valid, a_fe, a_pe, a_ov, a_data}, 0);
    chk("b_reset", {b_busy, b_valid, b_fe, b_pe, b_ov, b_data}, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Idle line for 20 cycles
    for (int i = 0; i < 20; i++) begin
      a_bit(1'b1);
      chk("a_idle", {a_busy, a_valid, a_fe, a_pe, a_ov, a_data}, 0);
    end

    // Single frame 4'hB, ack two cycles after delivery
    a_frame(4'hB, 1'b1, 1'b0, 1'b1, 1'b0);
    a_bit(1'b1);
    chk("a_hold_valid", a_valid, 1);
    a_ack = 1'b1;
    a_bit(1'b1);
    a_ack = 1'b0;
    chk("a_ack_valid", a_valid, 0);
    chk("a_ack_data", a_data, 4'hB);

    // Back-to-back 3 then C, each acked the cycle it appears
    a_frame(4'h3, 1'b1, 1'b0, 1'b1, 1'b0);
    a_frame(4'hC, 1'b1, 1'b1, 1'b1, 1'b0);
    a_ack = 1'b1;
    a_bit(1'b1);
    a_ack = 1'b0;
    chk("a_b2b_valid", a_valid, 0);
    chk("a_b2b_ovr", a_ov, 0);

    // Overrun: 5 then A without ack
    a_frame(4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    a_frame(4'hA, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("a_ovr_data", a_data, 4'h5);
    chk("a_ovr_valid", a_valid, 1);
    a_bit(1'b1);
    chk("a_ovr_pulse", a_ov, 0);
    a_ack = 1'b1;
    a_bit(1'b1);
    a_ack = 1'b0;
    chk("a_ovr_ack", a_valid, 0);

    // Framing error, line held low, then recovery with 4'h6
    a_frame(4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_fe_valid", a_valid, 0);
    for (int i = 0; i < 5; i++) begin
      a_bit(1'b0);
      chk("a_hold_low", {a_busy, a_valid, a_fe}, 3'b100);
    end
    a_bit(1'b1);
    chk("a_wait_exit", a_busy, 0);
    a_frame(4'h6, 1'b1, 1'b0, 1'b1, 1'b0);

    // Parity instance: good parity, then bad parity
    b_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    b_ack = 1'b1;
    b_bit(1'b1);
    b_ack = 1'b0;
    chk("b_ack_valid", b_valid, 0);
    b_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("b_pe_valid", b_valid, 0);
    b_bit(1'b1);
    chk("b_pe_pulse", b_pe, 0);

    // Bad stop with bad parity: only frame_err
    b_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_wait_busy", b_busy, 1);
    b_bit(1'b1);
    chk("b_wait_exit", b_busy, 0);

    // Odd data with parity 1, then replace with ack at the stop cycle
    b_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    b_frame(8'h1E, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset during data bit 3 while a word is held
    rw = 8'hF0;
    b_bit(1'b0);
    for (int i = 0; i < 3; i++) b_bit(rw[i]);
    b_serial = rw[3];
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    chk("b_mid_reset", {b_busy, b_valid, b_fe, b_pe, b_ov, b_data}, 0);
    $display("B reset mid-frame -> busy=%0b valid=%0b data_out=%h", b_busy, b_valid, b_data);
    b_bit(1'b1);
    chk("b_post_reset_idle", b_busy, 0);
    b_frame(8'h2D, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
